// File: rtl/vec_mem_arbiter.sv
// rtl/vec_mem_arbiter.sv - round-robin arbiter sharing one memory port between vector and scalar requesters
// One transaction in flight at a time; reads hold the grant until the response is handed back.
module vec_mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*SRC_W-1:0]  req_source,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      mem_req_valid,
  output logic                      mem_req_write,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_wdata,
  output logic [SRC_W-1:0]          mem_req_source,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  input  logic [SRC_W-1:0]          mem_rsp_source,
  output logic                      mem_rsp_ready,
  output logic                      src_mismatch,
  output logic [31:0]               grant_count
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   last_grant, owner, winner, cand;
  logic               any_req;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, data_q;
  logic [SRC_W-1:0]   src_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               mismatch_q;
  logic [31:0]        count_q;
  int                 idx;

  // Walk offsets from farthest to nearest so the nearest pending requester after last_grant wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = OWN_W'(idx);
      if (req_valid[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    rsp_valid     = '0;
    case (state_q)
      IDLE:     if (any_req) state_d = ISSUE;
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = wr_q ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) state_d = DELIVER;
      end
      DELIVER: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant  <= OWN_W'(NUM_REQ - 1);
      owner       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      src_q       <= '0;
      data_q      <= '0;
      req_ready_q <= '0;
      mismatch_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            req_ready_q <= NUM_REQ'(1) << winner;
            wr_q        <= req_write[winner];
            addr_q      <= req_addr[winner*ADDR_W +: ADDR_W];
            wdata_q     <= req_wdata[winner*DATA_W +: DATA_W];
            src_q       <= req_source[winner*SRC_W +: SRC_W];
            owner       <= winner;
            last_grant  <= winner;
            count_q     <= count_q + 32'd1;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            data_q <= mem_rsp_data;
            if (mem_rsp_source != src_q) mismatch_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_data       = data_q;
  assign mem_req_write  = wr_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_source = src_q;
  assign src_mismatch   = mismatch_q;
  assign grant_count    = count_q;

endmodule
